// File: rtl/pw_entry_ctrl.sv
// -----------------------------------------------------------------------------
// pw_entry_ctrl
//   Initiator side of the smart-lock password check. Collects up to four keypad
//   digits into a 16-bit code, issues a one-cycle start to the password checker
//   (data1 = entered code, data2 = stored password), waits for finish, then
//   shows unlock or fail for RESULT_CYCLES. Consecutive failures are counted;
//   reaching MAX_FAILS forces a LOCKOUT_CYCLES lockout.
//
//   Optional build macro: PW_PROGRAM_EN
//     When defined, the stored password becomes writable. This is only
//     possible during the unlock window that follows a successful check.
//       - Digits typed during that window are collected. Each digit restarts
//         the window so the new code can be typed at keypad pace.
//       - With four digits collected, key_enter together with key_clear loads
//         the stored password.
//       - The load holds unlock high for one extra cycle as acknowledgement.
//     When undefined, chk_data2 is the constant DEFAULT_PW.
//
// Ports
//   clk, reset           : clock (rising edge), synchronous active-high reset
//   key_valid / key_code : digit strobe and 4-bit digit value
//   key_enter, key_clear : submit / discard strobes
//   chk_start            : one-cycle start pulse to the checker
//   chk_data1, chk_data2 : entered code, stored password
//   chk_finish, chk_match: checker done strobe and its result
//   unlock, fail         : result indication, held RESULT_CYCLES
//   locked_out           : high throughout lockout
//   digit_cnt, fail_cnt  : digits entered so far, consecutive failures
// -----------------------------------------------------------------------------
module pw_entry_ctrl #(
   parameter logic [15:0] DEFAULT_PW     = 16'h1234,
   parameter int          MAX_FAILS      = 3,
   parameter int          LOCKOUT_CYCLES = 1000,
   parameter int          RESULT_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        key_enter,
   input  logic        key_clear,
   output logic        chk_start,
   output logic [15:0] chk_data1,
   output logic [15:0] chk_data2,
   input  logic        chk_finish,
   input  logic        chk_match,
   output logic        unlock,
   output logic        fail,
   output logic        locked_out,
   output logic [2:0]  digit_cnt,
   output logic [3:0]  fail_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_REQ, S_WAIT, S_RESULT, S_LOCKOUT
   } state_t;

   localparam logic [3:0]  MAX_FAILS_L = 4'(MAX_FAILS);
   localparam logic [15:0] RES_LOAD    = 16'(RESULT_CYCLES - 1);
   localparam logic [15:0] LOCK_LOAD   = 16'(LOCKOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] entry_q, entry_d;
   logic [2:0]  digit_cnt_q, digit_cnt_d;
   logic [3:0]  fail_cnt_q, fail_cnt_d;
   logic        match_q, match_d;     // result shown in the RESULT window
   logic [15:0] res_cnt_q, res_cnt_d;
   logic [15:0] lock_cnt_q, lock_cnt_d;
`ifdef PW_PROGRAM_EN
   logic [15:0] pw_q, pw_d;
`endif

   logic [15:0] entry_shift;
   logic [3:0]  fail_inc;

   assign entry_shift = {entry_q[11:0], key_code};
   assign fail_inc    = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         entry_q     <= '0;
         digit_cnt_q <= '0;
         fail_cnt_q  <= '0;
         match_q     <= 1'b0;
         res_cnt_q   <= '0;
         lock_cnt_q  <= '0;
`ifdef PW_PROGRAM_EN
         pw_q        <= DEFAULT_PW;
`endif
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         digit_cnt_q <= digit_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         match_q     <= match_d;
         res_cnt_q   <= res_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
`ifdef PW_PROGRAM_EN
         pw_q        <= pw_d;
`endif
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      entry_d     = entry_q;
      digit_cnt_d = digit_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      match_d     = match_q;
      res_cnt_d   = res_cnt_q;
      lock_cnt_d  = lock_cnt_q;
`ifdef PW_PROGRAM_EN
      pw_d        = pw_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (key_valid) begin
               entry_d     = entry_shift;
               digit_cnt_d = 3'd1;
               state_d     = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // clear beats enter beats digit
            if (key_clear) begin
               entry_d     = '0;
               digit_cnt_d = '0;
               state_d     = S_IDLE;
            end else if (key_enter) begin
               if (digit_cnt_q == 3'd4) begin
                  state_d = S_REQ;
               end else begin
                  // short entry fails locally, the checker is never asked
                  state_d     = S_RESULT;
                  match_d     = 1'b0;
                  fail_cnt_d  = fail_inc;
                  entry_d     = '0;
                  digit_cnt_d = '0;
                  res_cnt_d   = RES_LOAD;
               end
            end else if (key_valid && (digit_cnt_q < 3'd4)) begin
               entry_d     = entry_shift;
               digit_cnt_d = digit_cnt_q + 3'd1;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // finish is only looked at from here, never in the start cycle
            if (chk_finish) begin
               state_d     = S_RESULT;
               match_d     = chk_match;
               fail_cnt_d  = chk_match ? 4'd0 : fail_inc;
               entry_d     = '0;
               digit_cnt_d = '0;
               res_cnt_d   = RES_LOAD;
            end
         end
         S_RESULT: begin
            if (res_cnt_q == 16'd0) begin
               entry_d     = '0;
               digit_cnt_d = '0;
               if (fail_cnt_q >= MAX_FAILS_L) begin
                  state_d    = S_LOCKOUT;
                  lock_cnt_d = LOCK_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               res_cnt_d = res_cnt_q - 16'd1;
            end
`ifdef PW_PROGRAM_EN
            if (match_q) begin
               if (key_clear && key_enter && (digit_cnt_q == 3'd4)) begin
                  // load, then one more unlock cycle as acknowledgement
                  pw_d        = entry_q;
                  entry_d     = '0;
                  digit_cnt_d = '0;
                  res_cnt_d   = '0;
                  state_d     = S_RESULT;
               end else if (key_clear) begin
                  entry_d     = '0;
                  digit_cnt_d = '0;
               end else if (key_valid && (digit_cnt_q < 3'd4)) begin
                  entry_d     = entry_shift;
                  digit_cnt_d = digit_cnt_q + 3'd1;
                  res_cnt_d   = RES_LOAD;
                  state_d     = S_RESULT;
               end
            end
`endif
         end
         S_LOCKOUT: begin
            if (lock_cnt_q == 16'd0) begin
               fail_cnt_d = '0;
               state_d    = S_IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs (pure functions of state)
   always_comb begin
      chk_start  = (state_q == S_REQ);
      unlock     = (state_q == S_RESULT) && match_q;
      fail       = (state_q == S_RESULT) && !match_q;
      locked_out = (state_q == S_LOCKOUT);
      chk_data1  = entry_q;
      digit_cnt  = digit_cnt_q;
      fail_cnt   = fail_cnt_q;
`ifdef PW_PROGRAM_EN
      chk_data2  = pw_q;
`else
      chk_data2  = DEFAULT_PW;
`endif
   end

endmodule

// File: tb/tb_pw_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pw_entry_ctrl
//   Scoreboard bench for pw_entry_ctrl. Stimulus tasks update a keypad-level
//   model (digits typed, stored password, failure streak) and push expected
//   checker requests, result windows and lockouts into queues. An independent
//   negedge monitor pops and compares whenever the DUT presents one. A
//   responder plays the password checker with random latency.
// -----------------------------------------------------------------------------
module tb_pw_entry_ctrl;
   logic        clk = 1'b0;
   logic        reset, key_valid, key_enter, key_clear, chk_finish, chk_match;
   logic [3:0]  key_code;
   logic        chk_start, unlock, fail, locked_out;
   logic [15:0] chk_data1, chk_data2;
   logic [2:0]  digit_cnt;
   logic [3:0]  fail_cnt;

   localparam int RES_LEN  = 4;
   localparam int LOCK_LEN = 1000;
   localparam int MAX_F    = 3;

   typedef struct { logic unl; logic [3:0] fcnt; int len; } res_t;

   logic [31:0] start_q[$];
   res_t        res_q[$];
   int          lock_q[$];

   int n_chk = 0;
   int n_pass = 0;

   // keypad-level reference model
   logic [15:0] m_pw = 16'h1234;
   logic [15:0] m_code = 16'h0;
   int          m_n = 0;
   int          m_fails = 0;
   bit          m_ign = 1'b0;
   bit          m_lock = 1'b0;
   bit          resp_en = 1'b1;
   bit          mon_en = 1'b0;

   always #5 clk = ~clk;

   pw_entry_ctrl dut (
      .clk(clk), .reset(reset),
      .key_valid(key_valid), .key_code(key_code),
      .key_enter(key_enter), .key_clear(key_clear),
      .chk_start(chk_start), .chk_data1(chk_data1), .chk_data2(chk_data2),
      .chk_finish(chk_finish), .chk_match(chk_match),
      .unlock(unlock), .fail(fail), .locked_out(locked_out),
      .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Submission of the model's current entry
   task automatic submit();
      logic hit;
      hit = 1'b0;
      if (m_n == 4) begin
         start_q.push_back({m_code, m_pw});
         hit = (m_code == m_pw);
      end
      if (hit) begin
         m_fails = 0;
         res_q.push_back(res_t'{1'b1, 4'd0, RES_LEN});
      end else begin
         if (m_fails < 15) m_fails++;
         res_q.push_back(res_t'{1'b0, 4'(m_fails), RES_LEN});
         if (m_fails >= MAX_F) begin
            lock_q.push_back(LOCK_LEN);
            m_lock  = 1'b1;
            m_fails = 0;
         end
      end
      m_code = '0;
      m_n    = 0;
   endtask

   // One keypad cycle with any combination of strobes
   task automatic strobe(input logic v, input logic [3:0] d, input logic e, input logic c);
      bit sub;
      bit full;
      sub  = 1'b0;
      full = (m_n == 4);
      key_valid = v; key_code = d; key_enter = e; key_clear = c;
      tick();
      key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
      if (m_ign) begin
         chk("lockout_digit_cnt", digit_cnt, 0);
      end else begin
         if (m_n == 0) begin
            if (v) begin m_code = {m_code[11:0], d}; m_n = 1; end
         end else if (c) begin
            m_code = '0; m_n = 0;
         end else if (e) begin
            submit(); sub = 1'b1;
         end else if (v && m_n < 4) begin
            m_code = {m_code[11:0], d}; m_n++;
         end
         if (!sub) chk("digit_cnt", digit_cnt, m_n);
         else begin
            chk("start_after_enter", chk_start, full);
            if (!full) chk("short_entry_fail", fail, 1);
         end
      end
   endtask

   task automatic enter_code(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) strobe(1'b1, code[4*i +: 4], 1'b0, 1'b0);
      strobe(1'b0, 4'h0, 1'b1, 1'b0);
   endtask

   task automatic settle();
      repeat (16) tick();
      if (m_lock) begin
         chk("locked_out_on", locked_out, 1);
         m_ign = 1'b1;
         for (int i = 0; i < 20; i++)
            strobe(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
         m_ign = 1'b0;
         repeat (1000) tick();
         m_lock = 1'b0;
         chk("locked_out_off", locked_out, 0);
      end
      chk("fail_cnt_idle", fail_cnt, m_fails);
   endtask

   // Checker stand-in: random 1..5 cycle latency after start
   always begin
      @(negedge clk);
      if (resp_en && chk_start) begin
         repeat ($urandom_range(1, 5)) @(negedge clk);
         chk_finish = 1'b1;
         chk_match  = (chk_data1 == chk_data2);
         @(negedge clk);
         chk_finish = 1'b0;
         chk_match  = 1'b0;
         chk("result_latency", unlock || fail, 1);
      end
   end

   // Monitor: pops expectations whenever the DUT presents an event
   bit p_start = 1'b0, p_res = 1'b0, p_lock = 1'b0;
   int res_run = 0, res_len = 0, lock_run = 0, lock_len = 0;
   always @(negedge clk) begin
      logic [31:0] e;
      res_t r;
      if (mon_en) begin
         if (chk_start) begin
            if (p_start) begin
               n_chk++;
               $display("FAIL start_width: chk_start high for more than 1 cycle");
            end else if (start_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_start: data1=%h data2=%h", chk_data1, chk_data2);
            end else begin
               e = start_q.pop_front();
               chk("chk_data1", chk_data1, e[31:16]);
               chk("chk_data2", chk_data2, e[15:0]);
            end
         end
         p_start = chk_start;

         if ((unlock || fail) && !p_res) begin
            if (res_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_result: unlock=%0b fail=%0b", unlock, fail);
               res_len = 0;
            end else begin
               r = res_q.pop_front();
               chk("result_unlock", unlock, r.unl);
               chk("result_fail", fail, !r.unl);
               chk("result_fail_cnt", fail_cnt, r.fcnt);
               res_len = r.len;
            end
            res_run = 1;
         end else if (unlock || fail) begin
            res_run++;
         end else if (p_res) begin
            chk("result_len", res_run, res_len);
         end
         p_res = unlock || fail;

         if (locked_out && !p_lock) begin
            if (lock_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_lockout: fail_cnt=%0d", fail_cnt);
               lock_len = 0;
            end else begin
               lock_len = lock_q.pop_front();
            end
            lock_run = 1;
         end else if (locked_out) begin
            lock_run++;
         end else if (p_lock) begin
            chk("lockout_len", lock_run, lock_len);
         end
         p_lock = locked_out;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nd;
      logic [15:0] c;
      bit got;
      reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; key_enter = 1'b0; key_clear = 1'b0;
      chk_finish = 1'b0; chk_match = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_chk_start", chk_start, 0);
      chk("rst_unlock", unlock, 0);
      chk("rst_fail", fail, 0);
      chk("rst_locked_out", locked_out, 0);
      chk("rst_digit_cnt", digit_cnt, 0);
      chk("rst_fail_cnt", fail_cnt, 0);
      chk("rst_data1", chk_data1, 16'h0);
      chk("rst_data2", chk_data2, 16'h1234);
      reset  = 1'b0;
      mon_en = 1'b1;

      // correct code, then wrong code
      enter_code(16'h1234); settle();
      enter_code(16'hF1F1); settle();

      // reset while waiting for the checker, then a late finish
      resp_en = 1'b0;
      for (int i = 3; i >= 0; i--) strobe(1'b1, 4'(i + 5), 1'b0, 1'b0);
      key_enter = 1'b1; tick(); key_enter = 1'b0;
      start_q.push_back({m_code, m_pw});
      chk("wait_start", chk_start, 1);
      repeat (2) tick();
      reset = 1'b1; tick();
      chk("wrst_chk_start", chk_start, 0);
      chk("wrst_unlock", unlock, 0);
      chk("wrst_fail", fail, 0);
      chk("wrst_locked_out", locked_out, 0);
      chk("wrst_digit_cnt", digit_cnt, 0);
      chk("wrst_fail_cnt", fail_cnt, 0);
      chk("wrst_data1", chk_data1, 16'h0);
      chk("wrst_data2", chk_data2, m_pw);
      reset = 1'b0;
      m_code = '0; m_n = 0; m_fails = 0;
      chk_finish = 1'b1; chk_match = 1'b1; tick();
      chk_finish = 1'b0; chk_match = 1'b0;
      repeat (4) begin
         chk("late_finish_unlock", unlock, 0);
         chk("late_finish_fail", fail, 0);
         tick();
      end
      resp_en = 1'b1;

      // three mismatches in a row -> lockout
      enter_code(16'h1111); settle();
      enter_code(16'h2222); settle();
      enter_code(16'h3333); settle();

      // short entry
      strobe(1'b1, 4'h1, 1'b0, 1'b0); strobe(1'b1, 4'h2, 1'b0, 1'b0);
      strobe(1'b0, 4'h0, 1'b1, 1'b0); settle();
      // overflow: fifth digit ignored
      for (int i = 1; i <= 5; i++) strobe(1'b1, 4'(i), 1'b0, 1'b0);
      strobe(1'b0, 4'h0, 1'b1, 1'b0); settle();
      // clear together with a digit
      strobe(1'b1, 4'h1, 1'b0, 1'b0); strobe(1'b1, 4'h2, 1'b0, 1'b0);
      strobe(1'b1, 4'h5, 1'b0, 1'b1);

`ifdef PW_PROGRAM_EN
      // unlock, then program 9876 inside the unlock window:
      // window R0..R3 extended by each digit, load in R4, ack in R5
      enter_code(16'h1234);
      res_q[res_q.size() - 1].len = 6;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (unlock) got = 1'b1;
      end
      chk("prog_unlock_seen", got, 1);
      for (int i = 9; i >= 6; i--) begin
         key_valid = 1'b1; key_code = 4'(i);
         @(posedge clk); #1;
      end
      key_valid = 1'b0; key_enter = 1'b1; key_clear = 1'b1;
      @(posedge clk); #1;
      key_enter = 1'b0; key_clear = 1'b0;
      m_pw = 16'h9876;
      repeat (10) tick();
      chk("prog_data2", chk_data2, 16'h9876);
      enter_code(16'h9876); settle();
      enter_code(16'h1234); settle();
`endif

      // randomized sessions
      for (int it = 0; it < 30; it++) begin
         k = $urandom_range(0, 5);
         c = 16'($urandom);
         case (k)
            0: enter_code(m_pw);
            1: enter_code(c);
            2: begin
               nd = $urandom_range(1, 3);
               for (int j = 0; j < nd; j++) strobe(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
               strobe(1'b0, 4'h0, 1'b1, 1'b0);
            end
            3: begin
               if ($urandom_range(0, 1) == 1) c = m_pw;
               for (int i = 3; i >= 0; i--) strobe(1'b1, c[4*i +: 4], 1'b0, 1'b0);
               nd = $urandom_range(1, 2);
               for (int j = 0; j < nd; j++) strobe(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
               strobe(1'b0, 4'h0, 1'b1, 1'b0);
            end
            4: begin
               strobe(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
               strobe(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
               strobe(1'b0, 4'h0, 1'($urandom_range(0, 1)), 1'b1);
               enter_code(($urandom_range(0, 1) == 1) ? m_pw : c);
            end
            default: begin
               for (int j = 0; j < 3; j++) strobe(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
               strobe(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
               if (m_n != 0) strobe(1'b0, 4'h0, 1'b1, 1'b0);
            end
         endcase
         settle();
      end

      repeat (20) tick();
      chk("start_q_drained", start_q.size(), 0);
      chk("res_q_drained", res_q.size(), 0);
      chk("lock_q_drained", lock_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pw_entry_ctrl.md
Name: pw_entry_ctrl

Overview:
- Initiator side of the password-check handshake in the smart lock.
- Collects keypad digits into a 16-bit entered code, then pulses start to the password checker with data1 = entered code and data2 = stored password.
- Waits for finish, then drives unlock or fail.
- Counts consecutive failures and enforces a timed lockout.

Parameters:
- DEFAULT_PW, 16'h1234, stored password loaded at reset.
- MAX_FAILS, 3, consecutive failed checks that trigger lockout (1..15).
- LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (>=1).
- RESULT_CYCLES, 4, cycles unlock or fail is held high (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle strobe: key_code holds a digit.
- key_code  input  4  digit value 0x0..0xF.
- key_enter  input  1  one-cycle strobe: submit the entry.
- key_clear  input  1  one-cycle strobe: discard the entry.
- chk_start  output  1  one-cycle start pulse to the checker.
- chk_data1  output  16  entered code.
- chk_data2  output  16  stored password.
- chk_finish  input  1  checker done; chk_match is valid in the same cycle.
- chk_match  input  1  checker result.
- unlock  output  1  held high RESULT_CYCLES after a match.
- fail  output  1  held high RESULT_CYCLES after a mismatch or short entry.
- locked_out  output  1  high throughout lockout.
- digit_cnt  output  3  digits entered so far (0..4).
- fail_cnt  output  4  consecutive failures.

Behaviour:
- Reset values: all outputs 0; chk_data2 = DEFAULT_PW; state IDLE; entry register 0.
- Reset mid-operation aborts immediately and returns to these values. A late chk_finish arriving after reset is ignored.
- States: IDLE, COLLECT, REQ, WAIT, RESULT, LOCKOUT.
- IDLE: a key_valid shifts the entry, sets digit_cnt = 1, and moves to COLLECT. key_enter and key_clear are ignored.
- COLLECT, digit handling:
  - Each key_valid with digit_cnt < 4 does entry <= {entry[11:0], key_code} and digit_cnt + 1.
  - A 5th digit is ignored; no wrap and no shift.
- COLLECT, enter and clear:
  - key_enter with digit_cnt == 4 goes to REQ.
  - key_enter with digit_cnt < 4 is a failure: go to RESULT with fail, increment fail_cnt, no checker request.
  - key_clear zeroes the entry and digit_cnt and returns to IDLE.
- COLLECT, simultaneous strobes (same cycle): priority is key_clear > key_enter > key_valid.
- REQ: chk_start = 1 for exactly one cycle, with chk_data1 = entry; next state WAIT.
- WAIT:
  - chk_data1 and chk_data2 are held stable.
  - All key inputs are ignored.
  - chk_start = 0 even if WAIT lasts arbitrarily long; there is no timeout.
  - On chk_finish = 1, sample chk_match and go to RESULT.
  - chk_finish in the same cycle as chk_start is not accepted; it is only sampled from the first WAIT cycle.
- RESULT, on a match: unlock = 1 for RESULT_CYCLES; fail_cnt <= 0.
- RESULT, on a mismatch: fail = 1 for RESULT_CYCLES; fail_cnt saturates at 15.
- RESULT, exit:
  - The entry and digit_cnt clear on entry to RESULT.
  - Exit to LOCKOUT if fail_cnt >= MAX_FAILS after the update; otherwise exit to IDLE.
- LOCKOUT:
  - locked_out = 1 for LOCKOUT_CYCLES; all keys ignored.
  - On expiry: fail_cnt <= 0 and return to IDLE.
  - The lockout counter is 16 bits wide and counts down to 0.
- Latency: key_enter at cycle N gives chk_start at N+1. chk_finish at cycle M gives unlock or fail asserted at M+1.

Optional Feature:
- Macro: PW_PROGRAM_EN.
- When defined:
  - 4 digits followed by key_enter while key_clear is held high in the same cycle loads the stored password (chk_data2) with the entry.
  - Only legal within the RESULT window after a successful unlock. Otherwise it behaves as a normal key_clear.
  - A load pulses unlock for 1 extra cycle as acknowledgement.
- When undefined: chk_data2 is constant DEFAULT_PW, and key_clear + key_enter is always a clear.

Test Plan:
- Correct code:
  - Stimulus: reset; keys 1,2,3,4; enter; checker returns finish = 1, match = 1 three cycles after start.
  - Required: chk_start is one pulse with data1 = 16'h1234 and data2 = 16'h1234; unlock high 4 cycles; fail_cnt = 0.
- Wrong code:
  - Stimulus: keys F,1,F,1; enter; checker finish with match = 0.
  - Required: chk_data1 = 16'hF1F1; fail high 4 cycles; fail_cnt = 1.
- Lockout:
  - Stimulus: 3 consecutive mismatches.
  - Required: locked_out high exactly 1000 cycles; key presses during lockout give no chk_start and digit_cnt stays 0; fail_cnt = 0 after lockout.
- Entry edge cases:
  - Short entry: keys 1,2; enter gives no chk_start, fail pulse, fail_cnt + 1.
  - Overflow: keys 1,2,3,4,5; enter gives data1 = 16'h1234.
  - Simultaneous clear and digit: digit_cnt = 0.
- Reset during WAIT:
  - Stimulus: reset asserted during WAIT, then a late chk_finish.
  - Required: all outputs 0; the late chk_finish has no effect.
- PW_PROGRAM_EN:
  - Stimulus: unlock with 1234; within the RESULT window enter 9,8,7,6 with enter + clear.
  - Required: chk_data2 = 16'h9876; the next entry of 9876 unlocks and 1234 fails.
